// File: rtl/moore_rr_arbiter.sv
// Two-requester round-robin Moore arbiter with a one-cycle dead GAP between owners.
// Define MOORE_RR_ARB_TIMEOUT_EN to compile in forced release after MAX_HOLD grant cycles.
module moore_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic done,
   output logic gnt_a,
   output logic gnt_b,
   output logic busy,
   output logic owner,
   output logic timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_A = 2'b01,
      GNT_B = 2'b10,
      GAP   = 2'b11
   } state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;

   if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_params
      $error("moore_rr_arbiter: MAX_HOLD must lie in 2..2**CNT_W");
   end

   // On a tie the requester that did not own the resource last wins.
   function automatic state_t arbitrate(input logic ra, input logic rb, input logic last);
      state_t nxt;
      nxt = IDLE;
      if (ra && rb)  nxt = last ? GNT_A : GNT_B;
      else if (ra)   nxt = GNT_A;
      else if (rb)   nxt = GNT_B;
      return nxt;
   endfunction

`ifdef MOORE_RR_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;
   logic             hold_at_max;

   assign hold_at_max = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
`ifdef MOORE_RR_ARB_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE, GAP: state_d = arbitrate(req_a, req_b, owner_q);
         GNT_A: begin
            if (done || !req_a) state_d = GAP;
`ifdef MOORE_RR_ARB_TIMEOUT_EN
            else if (hold_at_max && req_b) begin
               state_d   = GAP;
               timeout_d = 1'b1;
            end
`endif
         end
         GNT_B: begin
            if (done || !req_b) state_d = GAP;
`ifdef MOORE_RR_ARB_TIMEOUT_EN
            else if (hold_at_max && req_a) begin
               state_d   = GAP;
               timeout_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (state_q == IDLE || state_q == GAP) begin
         if (state_d == GNT_A)      owner_d = 1'b0;
         else if (state_d == GNT_B) owner_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

`ifdef MOORE_RR_ARB_TIMEOUT_EN
   // Counter restarts on every grant entry and saturates so a lone holder is never evicted.
   always_comb begin
      hold_cnt_d = '0;
      if ((state_q == GNT_A || state_q == GNT_B) && state_d == state_q)
         hold_cnt_d = hold_at_max ? hold_cnt_q : hold_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign gnt_a = (state_q == GNT_A);
   assign gnt_b = (state_q == GNT_B);
   assign busy  = (state_q != IDLE);
   assign owner = owner_q;

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Self-checking bench for moore_rr_arbiter: directed scenarios plus randomized traffic
// compared against a grant-holder reference model.
module tb_moore_rr_arbiter;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 4;
`ifdef MOORE_RR_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_a = 1'b0, req_b = 1'b0, done = 1'b0;
   logic gnt_a, gnt_b, busy, owner, timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who holds the resource (-1 none), dead-cycle flag, last winner.
   int m_holder;
   bit m_gap;
   bit m_last;
   bit m_to;
   int m_held;

   moore_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .owner(owner), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_holder = -1;
      m_gap    = 1'b0;
      m_last   = 1'b1;
      m_to     = 1'b0;
      m_held   = 0;
   endtask

   task automatic model_step(input bit ra, input bit rb, input bit dn);
      bit want [2];
      want[0] = ra;
      want[1] = rb;
      m_to = 1'b0;
      if (m_holder >= 0) begin
         if (dn || !want[m_holder]) begin
            m_holder = -1;
            m_gap    = 1'b1;
         end else if (TO_EN && m_held == MAX_HOLD && want[1 - m_holder]) begin
            m_holder = -1;
            m_gap    = 1'b1;
            m_to     = 1'b1;
         end else begin
            m_held++;
         end
      end else begin
         m_gap = 1'b0;
         if (ra && rb)  m_holder = m_last ? 0 : 1;
         else if (ra)   m_holder = 0;
         else if (rb)   m_holder = 1;
         else           m_holder = -1;
         if (m_holder >= 0) begin
            m_last = (m_holder == 1);
            m_held = 1;
         end
      end
   endtask

   function automatic logic [4:0] model_out();
      return {m_holder == 0, m_holder == 1, (m_holder >= 0) || m_gap, m_last, m_to};
   endfunction

   task automatic tick(input bit ra, input bit rb, input bit dn);
      req_a = ra;
      req_b = rb;
      done  = dn;
      @(posedge clk);
      model_step(ra, rb, dn);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      done  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst   = 1'b0;
      req_a = 1'b1;
      req_b = 1'b1;
      done  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      obs = {gnt_a, gnt_b, busy, owner, timeout};
      n_tests++;
      if (obs !== 5'b00010) begin
         n_fail++;
         $display("FAIL reset_hold: got %b want %b", obs, 5'b00010);
      end
      rst = 1'b1;
      tick(1, 1, 0);
      obs = {gnt_a, gnt_b, busy, owner, timeout};
      n_tests++;
      if (obs !== 5'b10100) begin
         n_fail++;
         $display("FAIL reset_first_tie: got %b want %b", obs, 5'b10100);
      end
      do_reset();
      tick(0, 1, 0);
      obs = {gnt_a, gnt_b, busy, owner, timeout};
      n_tests++;
      if (obs !== 5'b01110) begin
         n_fail++;
         $display("FAIL reset_pre_async: got %b want %b", obs, 5'b01110);
      end
      #3 rst = 1'b0;
      #1;
      obs = {gnt_a, gnt_b, busy, owner, timeout};
      n_tests++;
      if (obs !== 5'b00010) begin
         n_fail++;
         $display("FAIL reset_async: got %b want %b", obs, 5'b00010);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_single();
      logic [2:0] stim [11] = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b100, 3'b000,
                                3'b000, 3'b001, 3'b100, 3'b001, 3'b000};
      logic [4:0] expv [11] = '{5'b10100, 5'b10100, 5'b10100, 5'b00100, 5'b10100, 5'b00100,
                                5'b00000, 5'b00000, 5'b10100, 5'b00100, 5'b00000};
      logic [4:0] obs;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         tick(stim[i][2], stim[i][1], stim[i][0]);
         obs = {gnt_a, gnt_b, busy, owner, timeout};
         n_tests++;
         if (obs !== expv[i]) begin
            n_fail++;
            $display("FAIL single_step%0d: got %b want %b", i, obs, expv[i]);
         end
      end
   endtask

   task automatic test_tie_and_withdraw();
      logic [2:0] stim [13] = '{3'b110, 3'b110, 3'b111, 3'b110, 3'b111, 3'b110, 3'b111,
                                3'b110, 3'b100, 3'b100, 3'b000, 3'b001, 3'b001};
      logic [4:0] expv [13] = '{5'b10100, 5'b10100, 5'b00100, 5'b01110, 5'b00110, 5'b10100,
                                5'b00100, 5'b01110, 5'b00110, 5'b10100, 5'b00100, 5'b00000,
                                5'b00000};
      logic [4:0] obs;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         tick(stim[i][2], stim[i][1], stim[i][0]);
         obs = {gnt_a, gnt_b, busy, owner, timeout};
         n_tests++;
         if (obs !== expv[i]) begin
            n_fail++;
            $display("FAIL tie_step%0d: got %b want %b", i, obs, expv[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [4:0] expv [7];
      logic [4:0] obs;
      for (int i = 0; i < 4; i++) expv[i] = 5'b10100;
      expv[4] = TO_EN ? 5'b00101 : 5'b10100;
      expv[5] = TO_EN ? 5'b01110 : 5'b10100;
      expv[6] = TO_EN ? 5'b01110 : 5'b10100;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         tick(1, 1, 0);
         obs = {gnt_a, gnt_b, busy, owner, timeout};
         n_tests++;
         if (obs !== expv[i]) begin
            n_fail++;
            $display("FAIL timeout_step%0d: got %b want %b", i, obs, expv[i]);
         end
      end
      do_reset();
      for (int i = 0; i < 12; i++) tick(1, 0, 0);
      obs = {gnt_a, gnt_b, busy, owner, timeout};
      n_tests++;
      if (obs !== 5'b10100) begin
         n_fail++;
         $display("FAIL timeout_lone_hold: got %b want %b", obs, 5'b10100);
      end
      tick(1, 0, 1);
      obs = {gnt_a, gnt_b, busy, owner, timeout};
      n_tests++;
      if (obs !== 5'b00100) begin
         n_fail++;
         $display("FAIL timeout_lone_release: got %b want %b", obs, 5'b00100);
      end
   endtask

   task automatic test_random();
      logic [4:0] obs;
      logic [4:0] expv;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
         obs  = {gnt_a, gnt_b, busy, owner, timeout};
         expv = model_out();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %b want %b", i, obs, expv);
         end
         n_tests++;
         if (gnt_a && gnt_b) begin
            n_fail++;
            $display("FAIL random_exclusive%0d: got gnt_a=%b gnt_b=%b want not both", i, gnt_a, gnt_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie_and_withdraw();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
